tx_instruction_sequencer: RTL and testbench

RAM-driven instruction sequencer for the transmit path. Fetches 128-bit instructions from the transmit instruction RAM, decodes them, and issues fire requests, trigger/LED updates and ADC-trigger strobes to the output control stage. Inter-instruction delays, external-trigger waits and eight hardware loop counters are timed here. Active while the output control stage is in RAM-control mode.

---
 rtl/tx_instruction_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_tx_instruction_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_instruction_sequencer.sv
// RAM-driven transmit instruction sequencer: fetch, decode, timed issue of fire/trigger/LED/ADC actions.
// Latency: 4 cycles minimum per instruction (FETCH, LATCH, EXEC, one DELAY), plus delay and handshake cycles.
// Backpressure: FIRE holds otxFireReq until itxFireAck; WAIT_EXT holds until itxExternalTrigger.
module tx_instruction_sequencer (
    input  logic         txCLK,
    input  logic         txRESET,
    input  logic         itxRun,
    input  logic         itxEmergency,
    input  logic         itxExternalTrigger,
    input  logic [127:0] itxInstructionMem,
    output logic [11:0]  otxInstructionReadAddr,
    output logic         otxFireReq,
    input  logic         itxFireAck,
    output logic [11:0]  otxFireAddr,
    output logic         otxTrigStrobe,
    output logic         otxLedStrobe,
    output logic         otxAdcTrigStrobe,
    output logic [7:0]   otxTrigValue,
    output logic [7:0]   otxLedValue,
    output logic         otxBusy,
    output logic         otxDone,
    output logic         otxError
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_ISSUE,
        S_WAIT_EXT,
        S_DELAY,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_FIRE       = 4'd1;
    localparam logic [3:0] OP_SET_TRIGS  = 4'd2;
    localparam logic [3:0] OP_SET_LEDS   = 4'd3;
    localparam logic [3:0] OP_ADC_TRIG   = 4'd4;
    localparam logic [3:0] OP_WAIT_EXT   = 4'd5;
    localparam logic [3:0] OP_LOOP_START = 4'd6;
    localparam logic [3:0] OP_LOOP_END   = 4'd7;
    localparam logic [3:0] OP_HALT       = 4'd8;

    state_t       state;
    state_t       stateNext;
    logic [127:0] instr;
    logic [31:0]  delayCnt;
    logic [29:0]  loopCnt [8];
    logic         branchTaken;

    logic [3:0]   opcode;
    logic [2:0]   loopIdx;
    logic [11:0]  branchTarget;
    logic [29:0]  loopCount;
    logic [7:0]   trigField;
    logic [7:0]   ledField;
    logic [11:0]  fireField;
    logic [31:0]  delayField;
    logic [29:0]  loopCur;
    logic         pcAtEnd;
    logic         execAct;
    logic         unusedInstrBits;

    assign opcode       = instr[3:0];
    assign loopIdx      = instr[6:4];
    assign branchTarget = instr[19:8];
    assign loopCount    = instr[49:20];
    assign trigField    = instr[57:50];
    assign ledField     = instr[65:58];
    assign fireField    = instr[77:66];
    assign delayField   = instr[127:96];
    assign unusedInstrBits = ^{instr[7], instr[95:78]};

    assign loopCur = loopCnt[loopIdx];
    assign pcAtEnd = (otxInstructionReadAddr == 12'hFFF);
    // Single-cycle opcodes take effect on the EXEC->DELAY edge only, so an abort in EXEC suppresses them.
    assign execAct = (state == S_EXEC) && (stateNext == S_DELAY);

    always_comb begin
        stateNext = state;
        if (itxEmergency) begin
            stateNext = S_ERROR;
        end else if (!itxRun) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  stateNext = S_FETCH;
                S_FETCH: stateNext = S_LATCH;
                S_LATCH: stateNext = S_EXEC;
                S_EXEC: begin
                    case (opcode)
                        OP_FIRE:     stateNext = S_ISSUE;
                        OP_WAIT_EXT: stateNext = S_WAIT_EXT;
                        OP_HALT:     stateNext = S_HALT;
                        OP_NOP, OP_SET_TRIGS, OP_SET_LEDS, OP_ADC_TRIG,
                        OP_LOOP_START, OP_LOOP_END:
                                     stateNext = S_DELAY;
                        default:     stateNext = S_ERROR;
                    endcase
                end
                S_ISSUE:    if (itxFireAck) stateNext = S_DELAY;
                S_WAIT_EXT: if (itxExternalTrigger) stateNext = S_DELAY;
                S_DELAY: begin
                    // The PC does not wrap: stepping past the last address is a program fault.
                    if (delayCnt == 32'd0)
                        stateNext = (!branchTaken && pcAtEnd) ? S_ERROR : S_FETCH;
                end
                S_HALT:  stateNext = S_HALT;
                S_ERROR: stateNext = S_ERROR;
                default: stateNext = S_ERROR;
            endcase
        end
    end

    always_ff @(posedge txCLK) begin
        if (txRESET) begin
            state                  <= S_IDLE;
            instr                  <= '0;
            delayCnt               <= '0;
            branchTaken            <= 1'b0;
            for (int i = 0; i < 8; i++) loopCnt[i] <= '0;
            otxInstructionReadAddr <= '0;
            otxFireReq             <= 1'b0;
            otxFireAddr            <= '0;
            otxTrigStrobe          <= 1'b0;
            otxLedStrobe           <= 1'b0;
            otxAdcTrigStrobe       <= 1'b0;
            otxTrigValue           <= '0;
            otxLedValue            <= '0;
            otxBusy                <= 1'b0;
            otxDone                <= 1'b0;
            otxError               <= 1'b0;
        end else begin
            state            <= stateNext;
            otxBusy          <= !(stateNext inside {S_IDLE, S_HALT, S_ERROR});
            otxDone          <= (stateNext == S_HALT);
            otxError         <= (stateNext == S_ERROR);
            otxFireReq       <= (stateNext == S_ISSUE);
            otxTrigStrobe    <= execAct && (opcode == OP_SET_TRIGS);
            otxLedStrobe     <= execAct && (opcode == OP_SET_LEDS);
            otxAdcTrigStrobe <= execAct && (opcode == OP_ADC_TRIG);

            case (state)
                S_IDLE: begin
                    if (stateNext == S_FETCH) otxInstructionReadAddr <= '0;
                end
                S_LATCH: begin
                    instr <= itxInstructionMem;
                end
                S_EXEC: begin
                    if (stateNext inside {S_DELAY, S_ISSUE, S_WAIT_EXT}) begin
                        delayCnt    <= delayField;
                        branchTaken <= 1'b0;
                    end
                    if (stateNext == S_ISSUE) otxFireAddr <= fireField;
                    if (execAct) begin
                        case (opcode)
                            OP_SET_TRIGS:  otxTrigValue <= trigField;
                            OP_SET_LEDS:   otxLedValue  <= ledField;
                            OP_LOOP_START: loopCnt[loopIdx] <= loopCount;
                            OP_LOOP_END: begin
                                if (loopCur > 30'd1) begin
                                    loopCnt[loopIdx] <= loopCur - 30'd1;
                                    branchTaken      <= 1'b1;
                                end else begin
                                    loopCnt[loopIdx] <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DELAY: begin
                    if (stateNext == S_FETCH)
                        otxInstructionReadAddr <= branchTaken ? branchTarget
                                                              : otxInstructionReadAddr + 12'd1;
                    else if (stateNext == S_DELAY)
                        delayCnt <= delayCnt - 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_instruction_sequencer.sv
// Scoreboard bench: a program-level interpreter predicts the event stream, a monitor checks DUT events against it.
module tb_tx_instruction_sequencer;

    logic         txCLK = 1'b0;
    logic         txRESET;
    logic         itxRun;
    logic         itxEmergency;
    logic         itxExternalTrigger;
    logic [127:0] itxInstructionMem;
    logic         itxFireAck;
    logic [11:0]  otxInstructionReadAddr;
    logic         otxFireReq;
    logic [11:0]  otxFireAddr;
    logic         otxTrigStrobe;
    logic         otxLedStrobe;
    logic         otxAdcTrigStrobe;
    logic [7:0]   otxTrigValue;
    logic [7:0]   otxLedValue;
    logic         otxBusy;
    logic         otxDone;
    logic         otxError;

    tx_instruction_sequencer dut (
        .txCLK                  (txCLK),
        .txRESET                (txRESET),
        .itxRun                 (itxRun),
        .itxEmergency           (itxEmergency),
        .itxExternalTrigger     (itxExternalTrigger),
        .itxInstructionMem      (itxInstructionMem),
        .otxInstructionReadAddr (otxInstructionReadAddr),
        .otxFireReq             (otxFireReq),
        .itxFireAck             (itxFireAck),
        .otxFireAddr            (otxFireAddr),
        .otxTrigStrobe          (otxTrigStrobe),
        .otxLedStrobe           (otxLedStrobe),
        .otxAdcTrigStrobe       (otxAdcTrigStrobe),
        .otxTrigValue           (otxTrigValue),
        .otxLedValue            (otxLedValue),
        .otxBusy                (otxBusy),
        .otxDone                (otxDone),
        .otxError               (otxError)
    );

    always #5 txCLK = ~txCLK;

    logic [127:0] mem [0:4095];
    always @(posedge txCLK) itxInstructionMem <= mem[otxInstructionReadAddr];

    localparam int K_TRIG = 1, K_LED = 2, K_ADC = 3, K_FIRE = 4, K_DONE = 5, K_ERR = 6;
    typedef struct { int kind; int val; } evt_t;
    evt_t expQ[$];

    int tests = 0;
    int fails = 0;
    int ackDelay = 0;
    bit spurAck = 1'b0;
    int extMode = 0;
    bit lenCheck = 1'b1;
    int adcSeen = 0;
    int ga = 0;
    logic [29:0] mLoop [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input int v);
        evt_t e;
        e.kind = k;
        e.val  = v;
        expQ.push_back(e);
    endtask

    task automatic checkEvt(input string nm, input int k, input int v);
        evt_t e;
        tests++;
        if (expQ.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event kind %0d val %0h with nothing expected", nm, k, v);
        end else begin
            e = expQ.pop_front();
            if (e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL %s: got kind %0d val %0h expected kind %0d val %0h", nm, k, v, e.kind, e.val);
            end
        end
    endtask

    function automatic logic [127:0] mkIns(input int op, input int idx, input int target, input int count,
                                           input int trig, input int led, input int faddr, input int dly);
        logic [127:0] w;
        w          = '0;
        w[3:0]     = op[3:0];
        w[6:4]     = idx[2:0];
        w[19:8]    = target[11:0];
        w[49:20]   = count[29:0];
        w[57:50]   = trig[7:0];
        w[65:58]   = led[7:0];
        w[77:66]   = faddr[11:0];
        w[127:96]  = dly;
        return w;
    endfunction

    // Program-level interpreter: walks the RAM image and lists the externally visible events in order.
    task automatic modelRun();
        int pc;
        int guard;
        logic [127:0] w;
        logic [2:0] idx;
        pc = 0;
        for (guard = 0; guard < 100000; guard++) begin
            w   = mem[pc];
            idx = w[6:4];
            case (w[3:0])
                4'd1: push(K_FIRE, int'(w[77:66]));
                4'd2: push(K_TRIG, int'(w[57:50]));
                4'd3: push(K_LED, int'(w[65:58]));
                4'd4: push(K_ADC, 0);
                4'd6: mLoop[idx] = w[49:20];
                4'd7: begin
                    if (mLoop[idx] > 30'd1) begin
                        mLoop[idx] = mLoop[idx] - 30'd1;
                        pc = int'(w[19:8]);
                        continue;
                    end
                    mLoop[idx] = '0;
                end
                4'd8: begin push(K_DONE, 0); return; end
                4'd0, 4'd5: ;
                default: begin push(K_ERR, 0); return; end
            endcase
            if (pc == 4095) begin
                push(K_ERR, 0);
                return;
            end
            pc++;
        end
    endtask

    task automatic stepN(input int n);
        repeat (n) @(negedge txCLK);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic waitEnd(input string nm, input int budget);
        int i;
        for (i = 0; i < budget && !(otxDone || otxError); i++) @(negedge txCLK);
        if (!(otxDone || otxError)) begin
            tests++;
            fails++;
            $display("FAIL %s: no done/error within %0d cycles", nm, budget);
        end
    endtask

    task automatic finishRun(input string nm);
        itxRun = 1'b0;
        stepN(2);
        chk({nm, "_idle_busy"}, otxBusy, 0);
        chk({nm, "_queue_empty"}, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic runProg(input string nm, input int budget);
        modelRun();
        itxRun = 1'b1;
        waitEnd(nm, budget);
        finishRun(nm);
    endtask

    task automatic emitSimple(input int n);
        for (int i = 0; i < n; i++) begin
            mem[ga] = mkIns($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 4095),
                            $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                            $urandom_range(0, 4095), $urandom_range(0, 3));
            ga++;
        end
    endtask

    task automatic genProg();
        int io, ii, so, si;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ga = 0;
        emitSimple($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) begin
            io = $urandom_range(0, 7);
            mem[ga] = mkIns(6, io, 0, $urandom_range(0, 3), 0, 0, 0, $urandom_range(0, 2));
            ga++;
            so = ga;
            emitSimple($urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1) begin
                ii = (io + $urandom_range(1, 7)) % 8;
                mem[ga] = mkIns(6, ii, 0, $urandom_range(0, 3), 0, 0, 0, $urandom_range(0, 2));
                ga++;
                si = ga;
                emitSimple($urandom_range(1, 2));
                mem[ga] = mkIns(7, ii, si, 0, 0, 0, 0, $urandom_range(0, 2));
                ga++;
            end
            emitSimple($urandom_range(0, 1));
            mem[ga] = mkIns(7, io, so, 0, 0, 0, 0, $urandom_range(0, 2));
            ga++;
        end
        emitSimple($urandom_range(0, 2));
        if ($urandom_range(0, 5) == 0) mem[ga] = mkIns($urandom_range(9, 15), 0, 0, 0, 0, 0, 0, 0);
        else                           mem[ga] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Fire-ack responder and external-trigger driver.
    initial begin
        int fireHigh;
        fireHigh = 0;
        itxFireAck = 1'b0;
        itxExternalTrigger = 1'b0;
        forever begin
            @(negedge txCLK);
            if (otxFireReq) begin
                fireHigh++;
                itxFireAck = (fireHigh == ackDelay + 1);
            end else begin
                fireHigh = 0;
                itxFireAck = spurAck ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            case (extMode)
                0:       itxExternalTrigger = 1'b0;
                1:       itxExternalTrigger = 1'b1;
                default: itxExternalTrigger = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Monitor: every strobe, fire request rise, done rise and error rise consumes one expected event.
    initial begin
        bit pf, pd, pe;
        int flen;
        pf = 0; pd = 0; pe = 0; flen = 0;
        forever begin
            @(negedge txCLK);
            if (!txRESET) begin
                if (otxTrigStrobe)    checkEvt("trig_event", K_TRIG, int'(otxTrigValue));
                if (otxLedStrobe)     checkEvt("led_event", K_LED, int'(otxLedValue));
                if (otxAdcTrigStrobe) begin
                    checkEvt("adc_event", K_ADC, 0);
                    adcSeen++;
                end
                if (otxFireReq && !pf) checkEvt("fire_event", K_FIRE, int'(otxFireAddr));
                if (otxFireReq) flen++;
                if (!otxFireReq && pf && lenCheck) chk("fire_req_length", flen, ackDelay + 1);
                if (!otxFireReq) flen = 0;
                if (otxDone && !pd)  checkEvt("done_event", K_DONE, 0);
                if (otxError && !pe) checkEvt("error_event", K_ERR, 0);
            end
            pf = otxFireReq;
            pd = otxDone;
            pe = otxError;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        txRESET = 1'b1;
        itxRun = 1'b0;
        itxEmergency = 1'b0;
        clearMem();
        for (int i = 0; i < 8; i++) mLoop[i] = '0;
        stepN(3);
        chk("reset_addr", otxInstructionReadAddr, 0);
        chk("reset_ctrl", {otxFireReq, otxTrigStrobe, otxLedStrobe, otxAdcTrigStrobe, otxBusy, otxDone, otxError}, 0);
        chk("reset_values", {otxFireAddr, otxTrigValue, otxLedValue}, 0);
        txRESET = 1'b0;
        stepN(2);
        chk("idle_after_reset", {otxBusy, otxDone, otxError}, 0);

        // NOP delay 0 then HALT: cycle-exact fetch and completion timing.
        mem[0] = mkIns(0, 0, 0, 0, 0, 0, 0, 0);
        mem[1] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
        modelRun();
        itxRun = 1'b1;
        stepN(1);
        chk("t1_busy_in_fetch", otxBusy, 1);
        stepN(3);
        chk("t1_addr_before_fetch1", otxInstructionReadAddr, 0);
        stepN(1);
        chk("t1_fetch1_at_plus4", otxInstructionReadAddr, 1);
        stepN(2);
        chk("t1_done_early", otxDone, 0);
        stepN(1);
        chk("t1_done_at_plus7", {otxDone, otxBusy}, 2'b10);
        finishRun("t1");

        // SET_TRIGS 0xA5 with delay 10.
        clearMem();
        mem[0] = mkIns(2, 0, 0, 0, 8'hA5, 0, 0, 10);
        mem[1] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
        modelRun();
        itxRun = 1'b1;
        stepN(4);
        chk("t2_strobe", {otxTrigStrobe, otxTrigValue}, 9'h1A5);
        stepN(1);
        chk("t2_strobe_single", {otxTrigStrobe, otxTrigValue}, 9'h0A5);
        stepN(9);
        chk("t2_addr_in_delay", otxInstructionReadAddr, 0);
        stepN(1);
        chk("t2_fetch_11_after_strobe", otxInstructionReadAddr, 1);
        waitEnd("t2", 50);
        finishRun("t2");

        // FIRE 0x123 with ack after 5 cycles.
        clearMem();
        ackDelay = 5;
        mem[0] = mkIns(1, 0, 0, 0, 0, 0, 12'h123, 0);
        mem[1] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
        modelRun();
        itxRun = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge txCLK);
            if (otxFireReq) begin
                hi++;
                chk("t3_fire_addr", otxFireAddr, 12'h123);
            end
        end
        chk("t3_fire_high_cycles", hi, 6);
        waitEnd("t3", 50);
        finishRun("t3");
        ackDelay = 0;

        // Loop count 3 and count 0 around an ADC trigger.
        clearMem();
        mem[0] = mkIns(6, 2, 0, 3, 0, 0, 0, 0);
        mem[1] = mkIns(4, 0, 0, 0, 0, 0, 0, 1);
        mem[2] = mkIns(7, 2, 1, 0, 0, 0, 0, 0);
        mem[3] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
        adcSeen = 0;
        runProg("t4_loop3", 200);
        chk("t4_adc_pulses_count3", adcSeen, 3);
        mem[0] = mkIns(6, 2, 0, 0, 0, 0, 0, 0);
        adcSeen = 0;
        runProg("t4_loop0", 200);
        chk("t4_adc_pulses_count0", adcSeen, 1);

        // WAIT_EXT with trigger already high releases after one cycle.
        clearMem();
        extMode = 1;
        mem[0] = mkIns(5, 0, 0, 0, 0, 0, 0, 0);
        mem[1] = mkIns(8, 0, 0, 0, 0, 0, 0, 0);
        modelRun();
        itxRun = 1'b1;
        stepN(5);
        chk("t5_wait_addr0", otxInstructionReadAddr, 0);
        stepN(1);
        chk("t5_wait_release_fetch1", otxInstructionReadAddr, 1);
        waitEnd("t5", 50);
        finishRun("t5");
        extMode = 0;

        // Emergency while a fire request is outstanding.
        clearMem();
        ackDelay = 1000;
        lenCheck = 1'b0;
        mem[0] = mkIns(1, 0, 0, 0, 0, 0, 12'h2AB, 0);
        push(K_FIRE, 12'h2AB);
        push(K_ERR, 0);
        itxRun = 1'b1;
        for (int i = 0; i < 10 && !otxFireReq; i++) @(negedge txCLK);
        chk("t6_fire_pending", otxFireReq, 1);
        stepN(2);
        itxEmergency = 1'b1;
        stepN(1);
        chk("t6_emergency_next_cycle", {otxFireReq, otxError, otxBusy}, 3'b010);
        itxEmergency = 1'b0;
        stepN(1);
        chk("t6_error_holds_with_run", otxError, 1);
        itxRun = 1'b0;
        stepN(1);
        chk("t6_error_cleared_to_idle", {otxError, otxBusy}, 0);
        finishRun("t6");
        ackDelay = 0;
        lenCheck = 1'b1;

        // Illegal opcode at address 0.
        clearMem();
        mem[0] = mkIns(15, 0, 0, 0, 0, 0, 0, 0);
        modelRun();
        itxRun = 1'b1;
        stepN(3);
        chk("t7_no_error_yet", otxError, 0);
        stepN(1);
        chk("t7_error_at_plus3", {otxError, otxBusy}, 2'b10);
        itxRun = 1'b0;
        stepN(1);
        chk("t7_error_cleared", otxError, 0);
        finishRun("t7");

        // Run dropped in the middle of a long DELAY.
        clearMem();
        mem[0] = mkIns(2, 0, 0, 0, 8'h3C, 0, 0, 20);
        push(K_TRIG, 8'h3C);
        itxRun = 1'b1;
        stepN(8);
        chk("t8_busy_mid_delay", otxBusy, 1);
        itxRun = 1'b0;
        stepN(1);
        chk("t8_abort_outputs", {otxBusy, otxFireReq, otxTrigStrobe, otxLedStrobe, otxAdcTrigStrobe}, 0);
        chk("t8_trig_value_held", otxTrigValue, 8'h3C);
        finishRun("t8");

        // Stepping past address 4095 is a fault.
        clearMem();
        mem[0] = mkIns(6, 0, 0, 2, 0, 0, 0, 0);
        mem[1] = mkIns(7, 0, 4095, 0, 0, 0, 0, 0);
        mem[4095] = mkIns(0, 0, 0, 0, 0, 0, 0, 0);
        runProg("t9_pc_end", 100);
        mem[4095] = '0;

        // Randomized programs with random ack latency, spurious acks and a random external trigger.
        extMode = 2;
        spurAck = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ackDelay = $urandom_range(0, 3);
            genProg();
            runProg("rand", 4000);
        end
        spurAck = 1'b0;
        extMode = 0;
        stepN(2);

        chk("final_queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
